// File: rtl/hamming_encoder_fifo.sv
`default_nettype none
// ============================================================================
// Module   : hamming_encoder_fifo
// Purpose  : Upstream stage of the 16-bit/21-bit Hamming link.  Accepts 16-bit
//            data words on a valid/ready handshake, encodes each one into a
//            21-bit even-parity codeword, and buffers the codewords in a
//            show-ahead FIFO.  The FIFO feeds the downstream transport and
//            the hamming_decoder.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH      FIFO entries; power of two, minimum 2          (default 4)
//   AW         pointer width; must equal log2(DEPTH)          (default 2)
// Ports
//   clk        in   1     system clock, rising edge
//   rst        in   1     synchronous active-high reset
//   in_data    in   16    data word to encode
//   in_valid   in   1     in_data valid this cycle
//   in_ready   out  1     block can accept a word (= !full)
//   out_code   out  21    codeword at FIFO head (meaningful when out_valid)
//   out_valid  out  1     FIFO not empty
//   out_ready  in   1     consumer takes out_code this cycle
//   count      out  AW+1  number of stored codewords, 0..DEPTH
// Optional build macro
//   ERR_INJECT_EN  adds inj_en (1) and inj_pos (5).  On a push with inj_en=1
//                  and inj_pos<=20, codeword bit inj_pos is inverted before
//                  it is stored; inj_pos 21..31 leaves the codeword clean.
// ============================================================================
module hamming_encoder_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   in_data,
  input  logic          in_valid,
  output logic          in_ready,
`ifdef ERR_INJECT_EN
  input  logic          inj_en,
  input  logic [4:0]    inj_pos,
`endif
  output logic [20:0]   out_code,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   count
);

  localparam logic [AW:0] C_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] C_PTR_ONE = AW'(1);

  // --------------------------------------------------------------------------
  // Storage and pointers
  // --------------------------------------------------------------------------
  logic [20:0]   mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;

  // --------------------------------------------------------------------------
  // Encoder
  // --------------------------------------------------------------------------
  logic [20:0]   w_data_cw;   // data bits placed, parity positions still zero
  logic [20:0]   w_clean_cw;  // complete even-parity codeword
  logic [20:0]   w_store_cw;  // codeword actually written into the FIFO

  always_comb begin
    w_data_cw        = '0;
    w_data_cw[2]     = in_data[15];
    w_data_cw[6:4]   = in_data[14:12];
    w_data_cw[14:8]  = in_data[11:5];
    w_data_cw[20:16] = in_data[4:0];
  end

  // Each parity bit covers the positions whose 1-based index has the
  // corresponding power-of-two bit set; parity slots are zero in w_data_cw
  // so they contribute nothing to the reductions.
  always_comb begin
    w_clean_cw     = w_data_cw;
    w_clean_cw[0]  = ^{w_data_cw[2],  w_data_cw[4],  w_data_cw[6],
                       w_data_cw[8],  w_data_cw[10], w_data_cw[12],
                       w_data_cw[14], w_data_cw[16], w_data_cw[18],
                       w_data_cw[20]};
    w_clean_cw[1]  = ^{w_data_cw[2],  w_data_cw[5],  w_data_cw[6],
                       w_data_cw[9],  w_data_cw[10], w_data_cw[13],
                       w_data_cw[14], w_data_cw[17], w_data_cw[18]};
    w_clean_cw[3]  = ^{w_data_cw[4],  w_data_cw[5],  w_data_cw[6],
                       w_data_cw[11], w_data_cw[12], w_data_cw[13],
                       w_data_cw[14], w_data_cw[19], w_data_cw[20]};
    w_clean_cw[7]  = ^w_data_cw[14:8];
    w_clean_cw[15] = ^w_data_cw[20:16];
  end

`ifdef ERR_INJECT_EN
  logic [20:0] w_flip;

  // A 21-bit shift by 21..31 already yields zero; the explicit range test
  // keeps the intent obvious.
  always_comb begin
    w_flip = '0;
    if (inj_en && (inj_pos <= 5'd20)) begin
      w_flip = 21'd1 << inj_pos;
    end
  end

  assign w_store_cw = w_clean_cw ^ w_flip;
`else
  assign w_store_cw = w_clean_cw;
`endif

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  // Full and empty come from the registered count only, so a pop in a full
  // cycle cannot open the input in that same cycle.
  assign w_full   = (r_count == C_FULL);
  assign w_empty  = (r_count == '0);
  assign w_push   = in_valid & ~w_full;
  assign w_pop    = out_ready & ~w_empty;

  // --------------------------------------------------------------------------
  // Control state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is intentionally not reset; the write is suppressed during reset
  // so a handshake in the reset cycle leaves no trace.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      mem[r_wr_ptr] <= w_store_cw;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign in_ready  = ~w_full;
  assign out_valid = ~w_empty;
  assign count     = r_count;

  // Stale entries survive reset, so the head is masked while empty to keep
  // out_code at zero rather than exposing old data.
  assign out_code  = w_empty ? 21'd0 : mem[r_rd_ptr];

endmodule
`default_nettype wire
